div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter SIZE, default 32, shall set the operand and result width in bits.
REQ-002 Parameter NREQ, default 4, shall set the number of requesters sharing one divider.
REQ-003 Parameter TIMEOUT, default 255, shall set the maximum WAIT cycles before a forced error response.
REQ-004 clk  in  1  shall be the sole clock; all state shall update on its rising edge.
REQ-005 reset  in  1  shall be a synchronous, active-high reset.
REQ-006 req  in  NREQ  shall carry per-requester request bits, each held high until the matching ack.
REQ-007 req_dividend  in  NREQ*SIZE  shall carry requester i's dividend in slice [i*SIZE +: SIZE].
REQ-008 req_divisor  in  NREQ*SIZE  shall carry requester i's divisor in slice [i*SIZE +: SIZE].
REQ-009 ack  out  NREQ  shall be a one-hot, one-cycle pulse marking operand acceptance.
REQ-010 resp_valid  out  NREQ  shall be a one-hot, one-cycle pulse marking result delivery.
REQ-011 resp_quotient, resp_remainder  out  SIZE each  shall carry the result of the last completed operation.
REQ-012 resp_error  out  1  shall flag divide-by-zero or timeout for the last operation.
REQ-013 resp_timeout  out  1  shall flag that the last operation timed out.
REQ-014 busy  out  1  shall be high in every state except IDLE.
REQ-015 div_start  out  1  shall be the start strobe to the shared divider.
REQ-016 div_dividend, div_divisor  out  SIZE each  shall be driven continuously from the latched operands.
REQ-017 div_done, div_error  in  1 each  shall be the divider's completion and error flags, sampled only in WAIT.
REQ-018 div_quotient, div_remainder  in  SIZE each  shall be the divider results, valid when div_done is high.

Function
REQ-019 The FSM shall have exactly four states: IDLE, ISSUE, WAIT and RESPOND.
REQ-020 In IDLE with req nonzero, the block shall grant round-robin: the first set bit at or after index (ptr+1) mod NREQ.
REQ-021 On the grant edge, the block shall latch owner, dividend and divisor, then enter ISSUE.
REQ-022 In ISSUE, ack[owner] and div_start shall both be 1 for exactly one cycle; the timer shall clear and the FSM shall enter WAIT.
REQ-023 In WAIT, the timer shall increment each cycle.
REQ-024 In WAIT with div_done=1, the block shall latch div_quotient, div_remainder and div_error, set timeout to 0, and enter RESPOND.
REQ-025 In WAIT with div_done=0 and timer==TIMEOUT, the block shall latch quotient=0, remainder=0, error=1 and timeout=1, then enter RESPOND.
REQ-026 If div_done=1 and timer==TIMEOUT occur together, div_done shall take priority.
REQ-027 In RESPOND, resp_valid[owner] shall be 1 for one cycle, ptr shall be set to owner, and the FSM shall return to IDLE.
REQ-028 resp_* data shall remain stable from RESPOND until the next RESPOND.
REQ-029 Latency shall be: grant edge -> ack/div_start in the next cycle; resp_valid in the cycle after div_done is sampled.
REQ-030 req bits shall be ignored outside IDLE; a req still high in IDLE after its ack shall count as a new request.
REQ-031 div_done outside WAIT shall be ignored.
REQ-032 The timer shall be $clog2(TIMEOUT+1) bits wide and shall never wrap.

Reset
REQ-033 While reset is high at a clock edge, the FSM shall go to IDLE, ptr shall go to NREQ-1 and timer to 0.
REQ-034 While reset is high at a clock edge, the latched operands and results, and all outputs, shall go to 0.
REQ-035 Reset shall take precedence over all other events.
REQ-036 Reset mid-operation shall abort the operation; no resp_valid shall be produced for it.

Verification
REQ-037 Single request: req=0001, 100/7, IDLE at cycle 0 -> ack=0001 and div_start=1 at cycle 1; resp_valid=0001 with q=14, r=2, error=0.
REQ-038 Divide by zero: req=0010, 5/0 -> resp_valid=0010, resp_error=1, resp_timeout=0.
REQ-039 Contention: req=1111 held after reset -> ack order 0, 1, 2, 3, then 0; exactly one resp_valid per ack, in the same order.
REQ-040 Timeout: a divider model that never asserts div_done, TIMEOUT=8 -> resp_valid after timer reaches 8; resp_error=1, resp_timeout=1, q=r=0.
REQ-041 Reset during WAIT: assert reset -> busy=0, all outputs 0 next cycle, no resp_valid; the next request is served from requester 0.
REQ-042 Coincidence: div_done=1 in the same cycle timer==TIMEOUT -> the divider result is returned with resp_timeout=0.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one external divider among NREQ requesters,
// with per-operation timeout and a registered response bus.
module div_arbiter #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_dividend,
    input  logic [NREQ*SIZE-1:0] req_divisor,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      resp_valid,
    output logic [SIZE-1:0]      resp_quotient,
    output logic [SIZE-1:0]      resp_remainder,
    output logic                 resp_error,
    output logic                 resp_timeout,
    output logic                 busy,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_dividend,
    output logic [SIZE-1:0]      div_divisor,
    input  logic                 div_done,
    input  logic                 div_error,
    input  logic [SIZE-1:0]      div_quotient,
    input  logic [SIZE-1:0]      div_remainder
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SIZE-1:0]    dividend_d, divisor_d;
    logic [SIZE-1:0]    quot_d, rem_d;
    logic               err_d, tmo_d;
    logic [NREQ-1:0]    ack_d, resp_valid_d;
    logic               div_start_d, busy_d;

    logic [SIZE-1:0]    dvd_arr [NREQ];
    logic [SIZE-1:0]    dvs_arr [NREQ];
    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    int unsigned        rr_idx;

    // Split the flat operand buses into per-requester words
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dvd_arr[g] = req_dividend[g*SIZE +: SIZE];
        assign dvs_arr[g] = req_divisor[g*SIZE +: SIZE];
    end

    // Round-robin search: first set request at or after ptr+1, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_idx = (32'(ptr_q) + 32'd1 + k) % NREQ;
            if (!gnt_found && req[PTR_W'(rr_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(rr_idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        timer_d      = timer_q;
        dividend_d   = div_dividend;
        divisor_d    = div_divisor;
        quot_d       = resp_quotient;
        rem_d        = resp_remainder;
        err_d        = resp_error;
        tmo_d        = resp_timeout;
        ack_d        = '0;
        resp_valid_d = '0;
        div_start_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    owner_d        = gnt_idx;
                    dividend_d     = dvd_arr[gnt_idx];
                    divisor_d      = dvs_arr[gnt_idx];
                    ack_d[gnt_idx] = 1'b1;
                    div_start_d    = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completing divider wins over a coincident timeout
                if (div_done) begin
                    quot_d                = div_quotient;
                    rem_d                 = div_remainder;
                    err_d                 = div_error;
                    tmo_d                 = 1'b0;
                    resp_valid_d[owner_q] = 1'b1;
                    state_d               = RESPOND;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    quot_d                = '0;
                    rem_d                 = '0;
                    err_d                 = 1'b1;
                    tmo_d                 = 1'b1;
                    resp_valid_d[owner_q] = 1'b1;
                    state_d               = RESPOND;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RESPOND: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= PTR_W'(NREQ - 1);
            owner_q        <= '0;
            timer_q        <= '0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b0;
            resp_timeout   <= 1'b0;
            ack            <= '0;
            resp_valid     <= '0;
            div_start      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            timer_q        <= timer_d;
            div_dividend   <= dividend_d;
            div_divisor    <= divisor_d;
            resp_quotient  <= quot_d;
            resp_remainder <= rem_d;
            resp_error     <= err_d;
            resp_timeout   <= tmo_d;
            ack            <= ack_d;
            resp_valid     <= resp_valid_d;
            div_start      <= div_start_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed + randomized bench for div_arbiter with a behavioural divider
// and round-robin reference model.
module tb_div_arbiter;

    localparam int unsigned SIZE = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] req_dividend, req_divisor;
    logic [NREQ-1:0]      ack, resp_valid;
    logic [SIZE-1:0]      resp_quotient, resp_remainder;
    logic                 resp_error, resp_timeout, busy, div_start;
    logic [SIZE-1:0]      div_dividend, div_divisor;
    logic                 div_done, div_error;
    logic [SIZE-1:0]      div_quotient, div_remainder;

    logic [SIZE-1:0]      opa [NREQ];
    logic [SIZE-1:0]      opb [NREQ];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    div_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .ack(ack), .resp_valid(resp_valid),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_error(resp_error), .resp_timeout(resp_timeout),
        .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_error(div_error),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_dividend[g*SIZE +: SIZE] = opa[g];
        assign req_divisor[g*SIZE +: SIZE]  = opb[g];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Behavioural divider: error on zero divisor with q=all-ones, r=dividend
    task automatic divm(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        output logic [SIZE-1:0] q, output logic [SIZE-1:0] r, output logic e);
        if (b == '0) begin
            q = '1; r = a; e = 1'b1;
        end else begin
            q = a / b; r = a % b; e = 1'b0;
        end
    endtask

    // Round-robin reference: first requester after 'last', wrapping
    function automatic int unsigned rr_pick(input int unsigned last, input logic [NREQ-1:0] m);
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    // One full transaction; entered in an IDLE cycle with req already driven
    task automatic serve(input int unsigned own, input int unsigned lat, input bit drop);
        logic [SIZE-1:0] eq, er;
        logic            ee;
        logic [NREQ-1:0] oh;
        oh = NREQ'(32'd1 << own);
        divm(opa[own], opb[own], eq, er, ee);
        tick();
        check("ack", 64'(ack), 64'(oh));
        check("div_start", 64'(div_start), 64'd1);
        check("busy_issue", 64'(busy), 64'd1);
        check("div_dividend", 64'(div_dividend), 64'(opa[own]));
        check("div_divisor", 64'(div_divisor), 64'(opb[own]));
        if (drop) req[own] = 1'b0;
        tick();
        check("ack_clear", 64'(ack), 64'd0);
        check("div_start_clear", 64'(div_start), 64'd0);
        repeat (lat) begin
            tick();
            check("early_resp", 64'(resp_valid), 64'd0);
        end
        div_done = 1'b1; div_quotient = eq; div_remainder = er; div_error = ee;
        tick();
        div_done = 1'b0; div_quotient = $urandom; div_remainder = $urandom; div_error = 1'b1;
        check("resp_valid", 64'(resp_valid), 64'(oh));
        check("resp_quotient", 64'(resp_quotient), 64'(eq));
        check("resp_remainder", 64'(resp_remainder), 64'(er));
        check("resp_error", 64'(resp_error), 64'(ee));
        check("resp_timeout", 64'(resp_timeout), 64'd0);
        tick();
        check("resp_valid_pulse", 64'(resp_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("resp_stable", 64'(resp_quotient), 64'(eq));
    endtask

    task automatic serve_timeout(input int unsigned own);
        logic [NREQ-1:0] oh;
        oh = NREQ'(32'd1 << own);
        div_quotient = 32'hdead_beef; div_remainder = 32'h1234_5678; div_error = 1'b0;
        tick();
        check("tmo_ack", 64'(ack), 64'(oh));
        req[own] = 1'b0;
        tick();
        repeat (TMO) begin
            tick();
            check("tmo_early", 64'(resp_valid), 64'd0);
        end
        tick();
        check("tmo_valid", 64'(resp_valid), 64'(oh));
        check("tmo_error", 64'(resp_error), 64'd1);
        check("tmo_flag", 64'(resp_timeout), 64'd1);
        check("tmo_q", 64'(resp_quotient), 64'd0);
        check("tmo_r", 64'(resp_remainder), 64'd0);
        tick();
        check("tmo_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned     last;
        int unsigned     own;
        logic [NREQ-1:0] mask;

        reset = 1'b1; req = '0; div_done = 1'b0; div_error = 1'b0;
        div_quotient = '0; div_remainder = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        reset = 1'b0;

        // 100 / 7 on requester 0
        opa[0] = 32'd100; opb[0] = 32'd7; req = 4'b0001;
        serve(0, 2, 1'b1);
        check("q_100_7", 64'(resp_quotient), 64'd14);
        check("r_100_7", 64'(resp_remainder), 64'd2);

        // 5 / 0 on requester 1
        opa[1] = 32'd5; opb[1] = 32'd0; req = 4'b0010;
        serve(1, 1, 1'b1);
        check("dz_error", 64'(resp_error), 64'd1);
        check("dz_timeout", 64'(resp_timeout), 64'd0);

        // Divider never completes on requester 2
        opa[2] = 32'd77; opb[2] = 32'd3; req = 4'b0100;
        serve_timeout(2);

        // Completion in the same cycle the timer reaches its limit
        opa[3] = 32'd1000; opb[3] = 32'd3; req = 4'b1000;
        serve(3, TMO, 1'b1);
        check("coinc_q", 64'(resp_quotient), 64'd333);

        // Reset while waiting on the divider
        opa[0] = 32'd50; opb[0] = 32'd5; req = 4'b0001;
        tick(); tick(); tick();
        reset = 1'b1; div_done = 1'b1; div_quotient = 32'd10; div_error = 1'b0;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_q", 64'(resp_quotient), 64'd0);
        check("mid_rst_r", 64'(resp_remainder), 64'd0);
        check("mid_rst_err", 64'(resp_error), 64'd0);
        check("mid_rst_tmo", 64'(resp_timeout), 64'd0);
        check("mid_rst_dvd", 64'(div_dividend), 64'd0);
        check("mid_rst_dvs", 64'(div_divisor), 64'd0);
        reset = 1'b0; div_done = 1'b0; req = '0;
        tick();
        check("post_rst_resp_valid", 64'(resp_valid), 64'd0);

        // All four held: order 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) begin opa[i] = $urandom; opb[i] = 32'($urandom_range(1, 1000)); end
        req = 4'b1111;
        for (int unsigned i = 0; i < 5; i++) serve(i % NREQ, $urandom_range(0, 4), 1'b0);
        req = '0;
        last = 0;

        // Random request masks against the round-robin model
        mask = '0;
        for (int n = 0; n < 40; n++) begin
            if (mask == '0) begin
                mask = NREQ'($urandom_range(1, 15));
                for (int i = 0; i < NREQ; i++) begin
                    if (mask[i]) begin
                        opa[i] = $urandom;
                        opb[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                    end
                end
                req = mask;
            end
            own = rr_pick(last, mask);
            serve(own, $urandom_range(0, 6), 1'b1);
            mask[own] = 1'b0;
            last = own;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
